// File: rtl/saturn_bus_ctrl.sv
// Saturn bus initiator: CPU nibble-transfer request -> command/address/data nibble stream.
// Optional SATURN_BUS_ADDR_CACHE_EN skips pointer loads when the shadow pointer already matches.
module saturn_bus_ctrl #(
  parameter int MAX_NIBS = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_clk_en,
  input  logic                    i_req,
  input  logic                    i_req_ptr,
  input  logic                    i_req_write,
  input  logic [19:0]             i_req_addr,
  input  logic [3:0]              i_req_len,
  input  logic [4*MAX_NIBS-1:0]   i_wdata,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*MAX_NIBS-1:0]   o_rdata,
  output logic                    o_bus_clk_en,
  output logic                    o_bus_is_data,
  output logic [3:0]              o_bus_nibble_out,
  input  logic [3:0]              i_bus_nibble_in
);
  localparam logic [3:0] CMD_PC_READ  = 4'h2;
  localparam logic [3:0] CMD_DP_READ  = 4'h3;
  localparam logic [3:0] CMD_PC_WRITE = 4'h4;
  localparam logic [3:0] CMD_DP_WRITE = 4'h5;
  localparam logic [3:0] CMD_LOAD_PC  = 4'h6;
  localparam logic [3:0] CMD_LOAD_DP  = 4'h7;

`ifdef SATURN_BUS_ADDR_CACHE_EN
  localparam logic USE_CACHE = 1'b1;
`else
  localparam logic USE_CACHE = 1'b0;
`endif

  // state names the item currently driven on the bus
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ADDR, S_XFER, S_DATA, S_TAIL} state_t;

  state_t                  state;
  logic                    ptr_q, wr_q;
  logic [19:0]             addr_q, addr_sh;
  logic [3:0]              nlast, cnt;
  logic [4*MAX_NIBS-1:0]   wdata_q;
  logic [19:0]             sh_pc, sh_dp;
  logic                    vld_pc, vld_dp;
  logic [19:0]             sel_sh;
  logic                    sel_vld, hit;
  logic [4:0]              nibs;

  assign sel_sh  = i_req_ptr ? sh_dp : sh_pc;
  assign sel_vld = i_req_ptr ? vld_dp : vld_pc;
  assign hit     = USE_CACHE && sel_vld && (sel_sh == i_req_addr);
  assign nibs    = {1'b0, nlast} + 5'd1;

  function automatic logic [3:0] xfer_cmd(input logic dp, input logic wr);
    case ({dp, wr})
      2'b00:   return CMD_PC_READ;
      2'b01:   return CMD_PC_WRITE;
      2'b10:   return CMD_DP_READ;
      default: return CMD_DP_WRITE;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state            <= S_IDLE;
      ptr_q            <= 1'b0;
      wr_q             <= 1'b0;
      addr_q           <= '0;
      addr_sh          <= '0;
      nlast            <= '0;
      cnt              <= '0;
      wdata_q          <= '0;
      sh_pc            <= '0;
      sh_dp            <= '0;
      vld_pc           <= 1'b0;
      vld_dp           <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_rdata          <= '0;
      o_bus_clk_en     <= 1'b0;
      o_bus_is_data    <= 1'b0;
      o_bus_nibble_out <= '0;
    end else begin
      // done is a single i_clk pulse, independent of the clock enable
      o_done <= 1'b0;
      if (i_clk_en) begin
        case (state)
          S_IDLE: if (i_req) begin
            ptr_q        <= i_req_ptr;
            wr_q         <= i_req_write;
            addr_q       <= i_req_addr;
            nlast        <= i_req_len - 4'd1;
            wdata_q      <= i_wdata;
            cnt          <= '0;
            o_busy       <= 1'b1;
            o_bus_clk_en <= 1'b1;
            o_bus_is_data <= 1'b0;
            if (!i_req_write) o_rdata <= '0;
            if (hit) begin
              state            <= S_XFER;
              o_bus_nibble_out <= xfer_cmd(i_req_ptr, i_req_write);
            end else begin
              state            <= S_LOAD;
              o_bus_nibble_out <= i_req_ptr ? CMD_LOAD_DP : CMD_LOAD_PC;
            end
          end
          S_LOAD: begin
            state            <= S_ADDR;
            cnt              <= '0;
            o_bus_is_data    <= 1'b1;
            o_bus_nibble_out <= addr_q[3:0];
            addr_sh          <= addr_q >> 4;
          end
          S_ADDR: if (cnt != 4'd4) begin
            cnt              <= cnt + 4'd1;
            o_bus_nibble_out <= addr_sh[3:0];
            addr_sh          <= addr_sh >> 4;
          end else begin
            cnt <= '0;
            if (ptr_q) begin sh_dp <= addr_q; vld_dp <= 1'b1; end
            else       begin sh_pc <= addr_q; vld_pc <= 1'b1; end
            // after a load the responder is already in read mode
            if (wr_q) begin
              state            <= S_XFER;
              o_bus_is_data    <= 1'b0;
              o_bus_nibble_out <= xfer_cmd(ptr_q, 1'b1);
            end else begin
              state            <= S_DATA;
              o_bus_nibble_out <= '0;
            end
          end
          S_XFER: begin
            state            <= S_DATA;
            cnt              <= '0;
            o_bus_is_data    <= 1'b1;
            o_bus_nibble_out <= wr_q ? wdata_q[3:0] : 4'h0;
          end
          S_DATA: begin
            if (!wr_q && cnt != 4'd0)
              o_rdata[{cnt - 4'd1, 2'b00} +: 4] <= i_bus_nibble_in;
            if (cnt == nlast) begin
              if (ptr_q) begin sh_dp <= addr_q + {15'd0, nibs}; vld_dp <= 1'b1; end
              else       begin sh_pc <= addr_q + {15'd0, nibs}; vld_pc <= 1'b1; end
              o_bus_clk_en     <= 1'b0;
              o_bus_is_data    <= 1'b0;
              o_bus_nibble_out <= '0;
              if (wr_q) begin
                state  <= S_IDLE;
                o_busy <= 1'b0;
                o_done <= 1'b1;
              end else begin
                state <= S_TAIL;
              end
            end else begin
              cnt              <= cnt + 4'd1;
              o_bus_nibble_out <= wr_q ? wdata_q[{cnt + 4'd1, 2'b00} +: 4] : 4'h0;
            end
          end
          S_TAIL: begin
            o_rdata[{nlast, 2'b00} +: 4] <= i_bus_nibble_in;
            state  <= S_IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_saturn_bus_ctrl.sv
// Bench for saturn_bus_ctrl: responder memory model on the bus, expected item streams built from request fields.
module tb_saturn_bus_ctrl;
  localparam logic [3:0] PC_READ = 4'h2, DP_READ = 4'h3, PC_WRITE = 4'h4, DP_WRITE = 4'h5;
  localparam logic [3:0] LOAD_PC = 4'h6, LOAD_DP = 4'h7;
`ifdef SATURN_BUS_ADDR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b1, ce = 1'b0, req = 1'b0, rq_ptr = 1'b0, rq_wr = 1'b0;
  logic [19:0] rq_addr = '0;
  logic [3:0]  rq_len = '0;
  logic [63:0] wdata = '0;
  logic        busy, done, bce, isd;
  logic [63:0] rdata;
  logic [3:0]  nib_out, nib_in;

  always #5 clk = ~clk;

  saturn_bus_ctrl dut (
    .i_clk(clk), .i_reset(rst_n), .i_clk_en(ce), .i_req(req), .i_req_ptr(rq_ptr),
    .i_req_write(rq_wr), .i_req_addr(rq_addr), .i_req_len(rq_len), .i_wdata(wdata),
    .o_busy(busy), .o_done(done), .o_rdata(rdata), .o_bus_clk_en(bce), .o_bus_is_data(isd),
    .o_bus_nibble_out(nib_out), .i_bus_nibble_in(nib_in)
  );

  // responder-side memory and a separate reference copy
  logic [3:0]  bus_mem [1048576];
  logic [3:0]  ref_mem [1048576];
  logic [19:0] rp [2];
  int          acnt;
  logic        rsel, rmode_wr;

  function automatic logic [3:0] init_nib(input logic [19:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8] ^ a[15:12] ^ a[19:16] ^ 4'h5;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acnt   <= 5;
      nib_in <= '0;
    end else if (ce && bce) begin
      if (!isd) begin
        case (nib_out)
          LOAD_PC:  begin rsel <= 1'b0; acnt <= 0; rmode_wr <= 1'b0; end
          LOAD_DP:  begin rsel <= 1'b1; acnt <= 0; rmode_wr <= 1'b0; end
          PC_READ:  begin rsel <= 1'b0; rmode_wr <= 1'b0; end
          DP_READ:  begin rsel <= 1'b1; rmode_wr <= 1'b0; end
          PC_WRITE: begin rsel <= 1'b0; rmode_wr <= 1'b1; end
          DP_WRITE: begin rsel <= 1'b1; rmode_wr <= 1'b1; end
          default:  ;
        endcase
      end else if (acnt < 5) begin
        rp[rsel][4*acnt +: 4] <= nib_out;
        acnt <= acnt + 1;
      end else begin
        if (rmode_wr) bus_mem[rp[rsel]] <= nib_out;
        else          nib_in <= bus_mem[rp[rsel]];
        rp[rsel] <= rp[rsel] + 20'd1;
      end
    end
  end

  int          errors = 0, checks = 0;
  logic [19:0] m_sh [2];
  bit          m_vld [2];
  logic [63:0] m_rdata = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one request: ce_mode 1 = clock enable high one cycle in three
  task automatic run(input bit p, input bit w, input logic [19:0] a, input logic [3:0] l,
                     input logic [63:0] wd, input int ce_mode, input int pulse_at,
                     input int abort_at, input string tag);
    logic [5:0]  items[$];
    logic [63:0] exp_rd;
    logic [19:0] ak;
    int n, idx, bound, cyc;
    bit hit, prev;
    n   = (l == 4'd0) ? 16 : int'(l);
    hit = CACHE && m_vld[p] && (m_sh[p] == a);
    if (!hit) begin
      items.push_back({2'b10, p ? LOAD_DP : LOAD_PC});
      for (int k = 0; k < 5; k++) items.push_back({2'b11, a[4*k +: 4]});
    end
    if (w || hit)
      items.push_back({2'b10, w ? (p ? DP_WRITE : PC_WRITE) : (p ? DP_READ : PC_READ)});
    for (int k = 0; k < n; k++) items.push_back({2'b11, w ? wd[4*k +: 4] : 4'h0});
    if (!w) items.push_back(6'h00);
    exp_rd = w ? m_rdata : 64'h0;
    for (int k = 0; k < n; k++) begin
      ak = a + 20'(k);
      if (w) ref_mem[ak] = wd[4*k +: 4];
      else   exp_rd[4*k +: 4] = ref_mem[ak];
    end

    req = 1'b1; rq_ptr = p; rq_wr = w; rq_addr = a; rq_len = l; wdata = wd; ce = 1'b1;
    @(posedge clk); @(negedge clk);
    req = 1'b0;
    idx = 0; bound = 400; cyc = 0;
    while (idx < items.size() && bound > 0) begin
      chk($sformatf("%s item%0d", tag, idx), {55'd0, busy, bce, isd, nib_out, done},
          {55'd0, 1'b1, items[idx], 1'b0});
      if (idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk({tag, " abort outs"}, {57'd0, busy, bce, isd, nib_out, done}, 64'd0);
        chk({tag, " abort rdata"}, rdata, 64'd0);
        m_vld[0] = 1'b0; m_vld[1] = 1'b0; m_rdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (idx == pulse_at) begin
        req = 1'b1; rq_ptr = ~p; rq_wr = ~w; rq_addr = 20'($urandom); wdata = {$urandom, $urandom};
      end else req = 1'b0;
      ce = (ce_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      prev = ce; cyc++;
      @(posedge clk); @(negedge clk);
      if (prev) idx++;
      bound--;
    end
    req = 1'b0;
    chk({tag, " in budget"}, 64'(bound > 0), 64'd1);
    chk({tag, " done"}, {59'd0, busy, bce, isd, done, |nib_out}, {59'd0, 5'b00010});
    chk({tag, " rdata"}, rdata, exp_rd);
    m_sh[p] = a + 20'(n); m_vld[p] = 1'b1; m_rdata = exp_rd;
    ce = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, " done pulse"}, 64'(done), 64'd0);
    ce = 1'b1;
  endtask

  initial begin
    bit          rp_p, rp_w;
    logic [19:0] ra;
    for (int i = 0; i < 1048576; i++) begin
      bus_mem[i] = init_nib(20'(i));
      ref_mem[i] = init_nib(20'(i));
    end
    m_vld[0] = 1'b0; m_vld[1] = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    chk("reset outs", {58'd0, busy, bce, isd, done, nib_out == 4'd0, 1'b0}, {58'd0, 6'b000010});
    chk("reset rdata", rdata, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run(0, 0, 20'h12345, 4'd4, 64'h0, 0, -1, -1, "s1 read");
    run(1, 1, 20'hABCDE, 4'd2, 64'h5A, 0, -1, -1, "s2 write");
    run(1, 0, 20'hABCDE, 4'd2, 64'h0, 0, -1, -1, "s2 readback");
    run(0, 0, 20'h00000, 4'd0, 64'h0, 0, -1, -1, "s3 len16");
    run(0, 0, 20'h00100, 4'd3, 64'h0, 0, -1, -1, "s4 a");
    run(0, 0, 20'h00103, 4'd2, 64'h0, 0, -1, -1, "s4 b");
    run(0, 0, 20'hFFFFE, 4'd4, 64'h0, 0, -1, -1, "s4 wrap a");
    run(0, 0, 20'h00002, 4'd3, 64'h0, 0, -1, -1, "s4 wrap b");
    run(0, 0, 20'h00200, 4'd2, 64'h0, 0, -1, -1, "s4 miss");
    run(1, 1, 20'h00500, 4'd3, 64'h0000_0000_0000_0ABC, 0, -1, -1, "dp wr a");
    run(1, 1, 20'h00503, 4'd2, 64'h0000_0000_0000_00E7, 0, -1, -1, "dp wr b");
    run(1, 0, 20'h00500, 4'd5, 64'h0, 0, -1, -1, "dp rd");
    run(0, 0, 20'h3C3C3, 4'd5, 64'h0, 0, 3, -1, "s5 req pulse");
    run(0, 0, 20'h77777, 4'd4, 64'h0, 0, -1, 3, "s5 abort");
    run(0, 0, 20'h77777, 4'd4, 64'h0, 0, -1, -1, "s5 after");
    run(0, 0, 20'h12345, 4'd4, 64'h0, 1, -1, -1, "s6 ce 1of3");

    for (int i = 0; i < 24; i++) begin
      rp_p = 1'($urandom);
      rp_w = 1'($urandom);
      ra   = (m_vld[rp_p] && $urandom_range(0, 1) == 1) ? m_sh[rp_p] : 20'($urandom);
      run(rp_p, rp_w, ra, 4'($urandom), {$urandom, $urandom}, $urandom_range(0, 1), -1, -1,
          $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
